imm_gen_stage: RTL and testbench

//  Registered, back-pressurable RISC-V immediate-generation stage for the decode pipeline.

---
 rtl/imm_gen_stage.sv | 167 ++++++++++++++++
 tb/tb_imm_gen_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
// RISC-V immediate-generation decode stage: classifies each instruction's format,
// builds the sign-extended immediate and queues the result in a 2-entry in-order buffer.
module imm_gen_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic             out_illegal,
   output logic [CNT_W-1:0] decode_cnt
);

   localparam int unsigned DEPTH = 2;
   localparam int unsigned FMT_W = 3;

   localparam logic [FMT_W-1:0] FMT_NONE = 3'd0;
   localparam logic [FMT_W-1:0] FMT_R    = 3'd1;
   localparam logic [FMT_W-1:0] FMT_I    = 3'd2;
   localparam logic [FMT_W-1:0] FMT_S    = 3'd3;
   localparam logic [FMT_W-1:0] FMT_B    = 3'd4;
   localparam logic [FMT_W-1:0] FMT_U    = 3'd5;
   localparam logic [FMT_W-1:0] FMT_J    = 3'd6;

   localparam logic IS_RV64 = (XLEN == 64);

   logic [XLEN-1:0]  dec_imm;
   logic [FMT_W-1:0] dec_fmt;
   logic             dec_ill;
   logic [6:0]       opcode;
   logic [2:0]       funct3;
   logic             is_shift;

   logic [XLEN-1:0]  imm_q [DEPTH];
   logic [XLEN-1:0]  imm_d [DEPTH];
   logic [FMT_W-1:0] fmt_q [DEPTH];
   logic [FMT_W-1:0] fmt_d [DEPTH];
   logic             ill_q [DEPTH];
   logic             ill_d [DEPTH];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push, pop;

   // Immediate decode, done before the buffer write
   always_comb begin
      opcode   = in_instr[6:0];
      funct3   = in_instr[14:12];
      is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
      dec_imm  = '0;
      dec_fmt  = FMT_NONE;
      dec_ill  = 1'b0;
      unique case (opcode)
         7'b0010011: begin
            dec_fmt = FMT_I;
            if (is_shift) begin
               dec_imm = IS_RV64 ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
            end else begin
               dec_imm = XLEN'($signed(in_instr[31:20]));
            end
         end
         7'b0011011: begin
            if (IS_RV64) begin
               dec_fmt = FMT_I;
               dec_imm = is_shift ? XLEN'(in_instr[24:20]) : XLEN'($signed(in_instr[31:20]));
            end else begin
               dec_ill = 1'b1;
            end
         end
         7'b0000011, 7'b1100111, 7'b1110011: begin
            dec_fmt = FMT_I;
            dec_imm = XLEN'($signed(in_instr[31:20]));
         end
         7'b0100011: begin
            dec_fmt = FMT_S;
            dec_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
         end
         7'b1100011: begin
            dec_fmt = FMT_B;
            dec_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                     in_instr[11:8], 1'b0}));
         end
         7'b0110111, 7'b0010111: begin
            dec_fmt = FMT_U;
            dec_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
         end
         7'b1101111: begin
            dec_fmt = FMT_J;
            dec_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                     in_instr[30:21], 1'b0}));
         end
         7'b0110011: dec_fmt = FMT_R;
         7'b0111011: begin
            if (IS_RV64) dec_fmt = FMT_R;
            else         dec_ill = 1'b1;
         end
         default: dec_ill = 1'b1;
      endcase
   end

   assign in_ready  = (count_q != 2'd2) && !rst;
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Buffer write/read pointers, occupancy and retire counter
   always_comb begin
      imm_d    = imm_q;
      fmt_d    = fmt_q;
      ill_d    = ill_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      cnt_d    = cnt_q;
      if (push) begin
         imm_d[wr_ptr_q] = dec_imm;
         fmt_d[wr_ptr_q] = dec_fmt;
         ill_d[wr_ptr_q] = dec_ill;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
         cnt_d    = CNT_W'(cnt_q + 1'b1);
      end
      unique case ({push, pop})
         2'b10:   count_d = 2'(count_q + 2'd1);
         2'b01:   count_d = 2'(count_q - 2'd1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            imm_q[i] <= '0;
            fmt_q[i] <= FMT_NONE;
            ill_q[i] <= 1'b0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         cnt_q    <= '0;
      end else begin
         imm_q    <= imm_d;
         fmt_q    <= fmt_d;
         ill_q    <= ill_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         cnt_q    <= cnt_d;
      end
   end

   // Head entry drives the outputs; all entries clear to zero on reset
   assign out_imm     = imm_q[rd_ptr_q];
   assign out_fmt     = fmt_q[rd_ptr_q];
   assign out_illegal = ill_q[rd_ptr_q];
   assign decode_cnt  = cnt_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: a 32-bit instance and a 64-bit instance with a
// narrow counter so that counter wrap is reachable.
module tb_imm_gen_stage;

   logic        clk = 1'b0;
   logic        rst;

   logic        in_valid0, in_ready0, out_valid0, out_ready0, out_illegal0;
   logic [31:0] in_instr0, out_imm0;
   logic [2:0]  out_fmt0;
   logic [15:0] decode_cnt0;

   logic        in_valid1, in_ready1, out_valid1, out_ready1, out_illegal1;
   logic [31:0] in_instr1;
   logic [63:0] out_imm1;
   logic [2:0]  out_fmt1;
   logic [1:0]  decode_cnt1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   imm_gen_stage #(.XLEN(32), .CNT_W(16)) d0 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid0), .in_ready(in_ready0), .in_instr(in_instr0),
      .out_valid(out_valid0), .out_ready(out_ready0),
      .out_imm(out_imm0), .out_fmt(out_fmt0), .out_illegal(out_illegal0),
      .decode_cnt(decode_cnt0)
   );

   imm_gen_stage #(.XLEN(64), .CNT_W(2)) d1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid1), .in_ready(in_ready1), .in_instr(in_instr1),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .out_imm(out_imm1), .out_fmt(out_fmt1), .out_illegal(out_illegal1),
      .decode_cnt(decode_cnt1)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      in_valid0 = 1'b0; in_instr0 = '0; out_ready0 = 1'b1;
      in_valid1 = 1'b0; in_instr1 = '0; out_ready1 = 1'b1;
      #1;
      chk("rst_in_ready",   64'(in_ready0),   64'd0);
      chk("rst_out_valid",  64'(out_valid0),  64'd0);
      chk("rst_out_imm",    64'(out_imm0),    64'd0);
      chk("rst_out_fmt",    64'(out_fmt0),    64'd0);
      chk("rst_illegal",    64'(out_illegal0), 64'd0);
      chk("rst_decode_cnt", 64'(decode_cnt0), 64'd0);
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 64'(in_ready0), 64'd1);

      // 1: ADDI, one-cycle latency
      in_valid0 = 1'b1; in_instr0 = 32'h0041_0193;
      tick();
      in_valid0 = 1'b0;
      chk("addi_valid",   64'(out_valid0),   64'd1);
      chk("addi_fmt",     64'(out_fmt0),     64'd2);
      chk("addi_imm",     64'(out_imm0),     64'd4);
      chk("addi_illegal", 64'(out_illegal0), 64'd0);
      tick();
      chk("addi_popped", 64'(out_valid0), 64'd0);
      chk("cnt_1",       64'(decode_cnt0), 64'd1);

      // 2: SW then BEQ back to back
      in_valid0 = 1'b1; in_instr0 = 32'h0032_2423;
      tick();
      chk("sw_fmt", 64'(out_fmt0), 64'd3);
      chk("sw_imm", 64'(out_imm0), 64'd8);
      in_instr0 = 32'hFE00_0FE3;
      tick();
      in_valid0 = 1'b0;
      chk("beq_valid", 64'(out_valid0), 64'd1);
      chk("beq_fmt",   64'(out_fmt0),   64'd4);
      chk("beq_imm",   64'(out_imm0),   64'hFFFF_FFFE);
      tick();
      chk("beq_popped", 64'(out_valid0), 64'd0);

      // 4: SLLI, SRAI, illegal opcode, OP-IMM-32 illegal at XLEN=32
      in_valid0 = 1'b1; in_instr0 = 32'h0050_9093;
      tick();
      chk("slli_imm", 64'(out_imm0), 64'd5);
      chk("slli_fmt", 64'(out_fmt0), 64'd2);
      in_instr0 = 32'h4030_D093;
      tick();
      chk("srai_imm", 64'(out_imm0), 64'd3);
      in_instr0 = 32'h0000_007F;
      tick();
      chk("ill_flag", 64'(out_illegal0), 64'd1);
      chk("ill_fmt",  64'(out_fmt0),     64'd0);
      chk("ill_imm",  64'(out_imm0),     64'd0);
      in_instr0 = 32'h0050_001B;
      tick();
      in_valid0 = 1'b0;
      chk("opimm32_rv32_ill", 64'(out_illegal0), 64'd1);
      chk("opimm32_rv32_fmt", 64'(out_fmt0),     64'd0);
      tick();
      chk("cnt_7", 64'(decode_cnt0), 64'd7);

      // 3: XLEN=64 instance: LUI, JAL, 6-bit shamt, then counter wrap
      in_valid1 = 1'b1; in_instr1 = 32'h8000_0137;
      tick();
      chk("lui64_fmt", 64'(out_fmt1), 64'd5);
      chk("lui64_imm", out_imm1,      64'hFFFF_FFFF_8000_0000);
      in_instr1 = 32'h0010_006F;
      tick();
      chk("jal64_fmt", 64'(out_fmt1), 64'd6);
      chk("jal64_imm", out_imm1,      64'd2048);
      in_instr1 = 32'h03F0_9093;
      tick();
      chk("slli64_imm", out_imm1, 64'd63);
      in_instr1 = 32'h0050_001B;
      tick();
      in_valid1 = 1'b0;
      chk("opimm32_rv64_fmt", 64'(out_fmt1),     64'd2);
      chk("opimm32_rv64_ill", 64'(out_illegal1), 64'd0);
      chk("opimm32_rv64_imm", out_imm1,          64'd5);
      chk("cnt64_3", 64'(decode_cnt1), 64'd3);
      tick();
      chk("cnt64_wrap", 64'(decode_cnt1), 64'd0);

      // 5: back-pressure, fresh counter
      rst = 1'b1;
      tick();
      rst = 1'b0;
      out_ready0 = 1'b0;
      in_valid0 = 1'b1; in_instr0 = 32'h0032_2423;
      tick();
      in_instr0 = 32'hFE00_0FE3;
      tick();
      chk("full_in_ready", 64'(in_ready0), 64'd0);
      chk("full_head_imm", 64'(out_imm0),  64'd8);
      in_instr0 = 32'h0041_0193;
      tick();
      chk("stall_head_imm", 64'(out_imm0), 64'd8);
      chk("stall_head_fmt", 64'(out_fmt0), 64'd3);
      chk("stall_in_ready", 64'(in_ready0), 64'd0);
      out_ready0 = 1'b1;
      tick();
      chk("drain_b_imm",    64'(out_imm0),  64'hFFFF_FFFE);
      chk("drain_in_ready", 64'(in_ready0), 64'd1);
      tick();
      in_valid0 = 1'b0;
      chk("drain_c_imm", 64'(out_imm0), 64'd4);
      chk("drain_c_fmt", 64'(out_fmt0), 64'd2);
      tick();
      chk("drain_empty", 64'(out_valid0),  64'd0);
      chk("cnt_3",       64'(decode_cnt0), 64'd3);

      // 6: reset with two entries held
      out_ready0 = 1'b0;
      in_valid0 = 1'b1; in_instr0 = 32'h0041_0193;
      tick(); tick();
      in_valid0 = 1'b0;
      chk("pre_rst_full", 64'(in_ready0), 64'd0);
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", 64'(out_valid0),  64'd0);
      chk("mid_rst_cnt",       64'(decode_cnt0), 64'd0);
      chk("mid_rst_in_ready",  64'(in_ready0),   64'd0);
      tick();
      rst = 1'b0;
      #1;
      chk("rel_rst_in_ready", 64'(in_ready0), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
